systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Parametrised operand sequencer for the MAX_DIM×MAX_DIM systolic multiplier. On a start pulse it reads A column-slices and B row-slices from the operand register banks, skews lane i by i cycles, and drives zero-padded left/up edges of the array, plus accumulator clear, valid and completion signals. It sits between the two operand register instances and the systolic array. It replaces the fixed 4×4 count-decoded feed with runtime N×K×M dimensions up to MAX_DIM.

## Interface
- DATA_WIDTH, 32, element width (8/16/32)
- MAX_DIM, 4, array edge length (2..8)
- DIM_W, $clog2(MAX_DIM), width of dimension fields and k address
- clk_i  in  1  clock, all logic rising-edge
- rst_ni  in  1  reset; asynchronous, active-low
- start_i  in  1  start request, sampled only in IDLE
- dim_n_i / dim_k_i / dim_m_i  in  DIM_W each  dimension minus one (0 → 1, MAX_DIM-1 → MAX_DIM), sampled with start_i
- rd_en_o  out  1  read strobe to both operand banks
- rd_k_o  out  DIM_W  k index: A column k, B row k
- rd_a_i  in  MAX_DIM*DATA_WIDTH  A[0..MAX_DIM-1][k], lane i at bits i*DATA_WIDTH; valid 1 cycle after rd_en_o
- rd_b_i  in  MAX_DIM*DATA_WIDTH  B[k][0..MAX_DIM-1], same packing and latency
- left_o  out  MAX_DIM*DATA_WIDTH  row feeds into array column 0
- up_o  out  MAX_DIM*DATA_WIDTH  column feeds into array row 0
- left_vld_o / up_vld_o  out  MAX_DIM  per-lane valid
- clr_o  out  1  one-cycle accumulator clear
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  see Configuration

## Operation
- FSM: IDLE → FEED → DRAIN → DONE → IDLE.
- IDLE: start_i=1 latches dims into n,k,m, zeroes the cycle counter, and moves to FEED.
- FEED: rd_en_o=1, rd_k_o counts 0..K-1 (K=dim_k+1). After rd_k_o=K-1, move to DRAIN.
- DRAIN: counter runs until the done cycle (see Timing), then DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- Skew: lane i of A and of B passes through i+1 registers (skew_line, depth i+1). A valid bit travels alongside each element.
- Masking: lane i of left_o is zero and invalid when i>dim_n. Lane j of up_o is zero and invalid when j>dim_m. Outside a valid slot, data is forced to 0, never held.
- Arithmetic: no arithmetic on data. The counter is wide enough for 3*MAX_DIM+2 with no wrap.
- start_i outside IDLE is ignored; it neither restarts nor queues.
- Reset at any time clears the FSM to IDLE and clears all skew registers. Outputs take reset values immediately; no partial done.

## Timing
- Cycle 0 is the cycle start_i is sampled in IDLE.
- clr_o = 1 in cycle 1 only.
- rd_k_o = k in cycle 1+k; rd_a_i/rd_b_i for that k are present in cycle 2+k.
- left_o lane i carries A[i][k] in cycle 3+k+i. up_o lane j carries B[k][j] in cycle 3+k+j.
- done_o pulses in cycle K+N+M+2, with N=dim_n+1 and M=dim_m+1.
- busy_o is high from cycle 1 through the done cycle inclusive. A new start is accepted from the cycle after done.
- Reset values: all outputs 0 (busy_o, done_o, clr_o, rd_en_o, err_o, data, valids).

## Configuration
- FEEDER_ERR_EN defined: start_i=1 while busy_o=1 pulses err_o for one cycle. The running operation is unaffected.
- FEEDER_ERR_EN undefined: err_o is tied to 0 and no detection logic is built.

## Structure
- Shared package matmul_pkg holds:
  - the FSM state enum {IDLE, FEED, DRAIN, DONE};
  - the DIM_W helper;
  - the lane-packing slice macro/function, shared with the operand registers and the array.
- One sub-module, skew_line: parametrised DEPTH×(DATA_WIDTH+1) shift register with async active-low clear. It is instantiated per lane via generate.

## Test plan
- MAX_DIM=4, N=K=M=4, A=I, B[k][j]=4k+j+1, start in cycle 0:
  - up_o lane 3 shows 4,8,12,16 in cycles 6..9;
  - done_o in cycle 14;
  - busy_o high in cycles 1..14.
- N=2, K=3, M=1: lanes 2,3 of left_o and lanes 1..3 of up_o stay 0 and invalid; done_o in cycle 8.
- N=K=M=1: single read at rd_k_o=0 in cycle 1; left_o lane 0 valid in cycle 3 only; done_o in cycle 5.
- start_i pulsed in cycles 0 and 4:
  - second start ignored, done_o still in cycle 14;
  - with FEEDER_ERR_EN, err_o=1 in cycle 5.
- rst_ni low in cycle 6 of a 4×4×4 run: all outputs 0 immediately; no done_o. A restart after release completes normally.
- Back-to-back: start in the cycle after done_o is accepted; clr_o pulses one cycle later.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the systolic matrix-multiply slice.
//   feeder_state_e : sequencing states of the operand feeder
//   dim_w()        : width of a dimension field / k address for a given array edge
//   lane_lsb()     : bit offset of lane 'lane' in a packed lane bus of 'width'-bit elements;
//                    used as bus[lane_lsb(i, W) +: W] by the operand registers, feeder and array
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    DONE
  } feeder_state_e;

  function automatic int unsigned dim_w(input int unsigned max_dim);
    return (max_dim > 1) ? $clog2(max_dim) : 1;
  endfunction

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/skew_line.sv
// DEPTH-stage shift register of (DATA_WIDTH+1)-bit words, {valid, data}, used to delay one
// operand lane. Asynchronous active-low clear empties every stage.
//   clk_i  : clock
//   rst_ni : asynchronous active-low clear
//   d_i    : word entering stage 0
//   q_o    : word leaving the last stage (DEPTH cycles later)
module skew_line #(
  parameter int unsigned DEPTH      = 1,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH:0]   d_i,
  output logic [DATA_WIDTH:0]   q_o
);

  logic [DATA_WIDTH:0] sr_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < DEPTH; s++) begin
        sr_q[s] <= '0;
      end
    end else begin
      sr_q[0] <= d_i;
      for (int s = 1; s < DEPTH; s++) begin
        sr_q[s] <= sr_q[s-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Operand sequencer for the MAX_DIM x MAX_DIM systolic multiplier. On start it reads K
// A-column / B-row slices, skews lane i by i cycles and drives the array's left/up edges with
// zero padding outside valid slots, plus accumulator clear, busy and done.
// Optional feature: define FEEDER_ERR_EN to pulse err_o when start_i arrives while busy.
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   start_i                    : start request, sampled only when idle
//   dim_n_i/dim_k_i/dim_m_i    : dimensions minus one, sampled with start_i
//   rd_en_o, rd_k_o            : read strobe and k index to both operand banks
//   rd_a_i, rd_b_i             : A column k / B row k, one cycle after rd_en_o
//   left_o/left_vld_o          : row feeds into array column 0
//   up_o/up_vld_o              : column feeds into array row 0
//   clr_o, busy_o, done_o      : accumulator clear, in-progress, completion pulse
//   err_o                      : start-while-busy pulse (0 unless FEEDER_ERR_EN)
module systolic_feeder
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_DIM    = 4,
  parameter int unsigned DIM_W      = dim_w(MAX_DIM)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [DIM_W-1:0]              dim_n_i,
  input  logic [DIM_W-1:0]              dim_k_i,
  input  logic [DIM_W-1:0]              dim_m_i,
  output logic                          rd_en_o,
  output logic [DIM_W-1:0]              rd_k_o,
  input  logic [MAX_DIM*DATA_WIDTH-1:0] rd_a_i,
  input  logic [MAX_DIM*DATA_WIDTH-1:0] rd_b_i,
  output logic [MAX_DIM*DATA_WIDTH-1:0] left_o,
  output logic [MAX_DIM*DATA_WIDTH-1:0] up_o,
  output logic [MAX_DIM-1:0]            left_vld_o,
  output logic [MAX_DIM-1:0]            up_vld_o,
  output logic                          clr_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
);

  // Counter reaches K+N+M+1 <= 3*MAX_DIM+1 at most; sized with headroom so it never wraps.
  localparam int unsigned CntW = $clog2(3 * MAX_DIM + 3);
  typedef logic [CntW-1:0] cnt_t;

  feeder_state_e    state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic [DIM_W-1:0] n_q, k_q, m_q;
  logic             rd_vld_q;
  cnt_t             drain_last;

  // Counter holds (cycle - 1); DRAIN ends one cycle before the done cycle K+N+M+2.
  assign drain_last = cnt_t'(n_q) + cnt_t'(k_q) + cnt_t'(m_q) + cnt_t'(3);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = FEED;
          cnt_d   = '0;
        end
      end
      FEED: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == cnt_t'(k_q)) state_d = DRAIN;
      end
      DRAIN: begin
        cnt_d = cnt_q + cnt_t'(1);
        if (cnt_q == drain_last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      n_q      <= '0;
      k_q      <= '0;
      m_q      <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_vld_q <= rd_en_o;
      if (state_q == IDLE && start_i) begin
        n_q <= dim_n_i;
        k_q <= dim_k_i;
        m_q <= dim_m_i;
      end
    end
  end

  assign rd_en_o = (state_q == FEED);
  assign rd_k_o  = rd_en_o ? cnt_q[DIM_W-1:0] : '0;
  assign clr_o   = (state_q == FEED) && (cnt_q == '0);
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);

  // Masking is applied at the skew input so inactive lanes carry zeros through the line and
  // data is never held outside a valid slot.
  for (genvar i = 0; i < MAX_DIM; i++) begin : g_lane
    localparam logic [DIM_W-1:0] Lane = DIM_W'(i);

    logic                  a_vld, b_vld;
    logic [DATA_WIDTH:0]   a_in, b_in, a_out, b_out;

    assign a_vld = rd_vld_q && (Lane <= n_q);
    assign b_vld = rd_vld_q && (Lane <= m_q);
    assign a_in  = {a_vld, a_vld ? rd_a_i[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] : '0};
    assign b_in  = {b_vld, b_vld ? rd_b_i[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] : '0};

    skew_line #(
      .DEPTH      (i + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_skew_a (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (a_in),
      .q_o    (a_out)
    );

    skew_line #(
      .DEPTH      (i + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_skew_b (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (b_in),
      .q_o    (b_out)
    );

    assign left_o[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = a_out[DATA_WIDTH-1:0];
    assign up_o[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]   = b_out[DATA_WIDTH-1:0];
    assign left_vld_o[i] = a_out[DATA_WIDTH];
    assign up_vld_o[i]   = b_out[DATA_WIDTH];
  end

`ifdef FEEDER_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= start_i && busy_o;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder (MAX_DIM=4, DATA_WIDTH=32). Expected outputs come
// from a cycle-indexed model of the timing rules over the stored A/B matrices.
module tb_systolic_feeder;

  localparam int unsigned DW   = 32;
  localparam int unsigned MD   = 4;
  localparam int unsigned DIMW = 2;

  typedef struct packed {
    logic            rd_en;
    logic [DIMW-1:0] rd_k;
    logic            clr;
    logic            busy;
    logic            done;
    logic            err;
    logic [MD-1:0]   lv;
    logic [MD-1:0]   uv;
    logic [MD*DW-1:0] left;
    logic [MD*DW-1:0] up;
  } exp_t;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            start_i = 1'b0;
  logic [DIMW-1:0] dim_n_i = '0, dim_k_i = '0, dim_m_i = '0;
  logic            rd_en_o;
  logic [DIMW-1:0] rd_k_o;
  logic [MD*DW-1:0] rd_a, rd_b, left_o, up_o;
  logic [MD-1:0]   left_vld_o, up_vld_o;
  logic            clr_o, busy_o, done_o, err_o;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] a_mat [MD][MD];
  logic [DW-1:0] b_mat [MD][MD];

  always #5 clk_i = ~clk_i;

  systolic_feeder #(
    .DATA_WIDTH (DW),
    .MAX_DIM    (MD)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .dim_n_i    (dim_n_i),
    .dim_k_i    (dim_k_i),
    .dim_m_i    (dim_m_i),
    .rd_en_o    (rd_en_o),
    .rd_k_o     (rd_k_o),
    .rd_a_i     (rd_a),
    .rd_b_i     (rd_b),
    .left_o     (left_o),
    .up_o       (up_o),
    .left_vld_o (left_vld_o),
    .up_vld_o   (up_vld_o),
    .clr_o      (clr_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  // Operand banks: one-cycle read latency; garbage when not read so stale data shows up.
  always @(posedge clk_i) begin
    for (int i = 0; i < MD; i++) begin
      if (rd_en_o) begin
        rd_a[i*DW +: DW] <= a_mat[i][rd_k_o];
        rd_b[i*DW +: DW] <= b_mat[rd_k_o][i];
      end else begin
        rd_a[i*DW +: DW] <= $urandom;
        rd_b[i*DW +: DW] <= $urandom;
      end
    end
  end

  // Expected outputs in cycle c of an op (c=0: start sampled); sp = extra start cycle or -1.
  function automatic exp_t model(input int c, input int dn, input int dk, input int dm,
                                 input int sp);
    exp_t e;
    int kk, nn, mm, d, k;
    kk = dk + 1;
    nn = dn + 1;
    mm = dm + 1;
    d  = kk + nn + mm + 2;
    e = '0;
    e.rd_en = (c >= 1) && (c <= kk);
    e.rd_k  = e.rd_en ? DIMW'(c - 1) : '0;
    e.clr   = (c == 1);
    e.busy  = (c >= 1) && (c <= d);
    e.done  = (c == d);
`ifdef FEEDER_ERR_EN
    e.err   = (sp >= 0) && (c == sp + 1);
`else
    e.err   = 1'b0;
`endif
    for (int i = 0; i < MD; i++) begin
      k = c - 3 - i;
      if (i <= dn && k >= 0 && k < kk) begin
        e.lv[i] = 1'b1;
        e.left[i*DW +: DW] = a_mat[i][k];
      end
      if (i <= dm && k >= 0 && k < kk) begin
        e.uv[i] = 1'b1;
        e.up[i*DW +: DW] = b_mat[k][i];
      end
    end
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.rd_en = rd_en_o;
    o.rd_k  = rd_k_o;
    o.clr   = clr_o;
    o.busy  = busy_o;
    o.done  = done_o;
    o.err   = err_o;
    o.lv    = left_vld_o;
    o.uv    = up_vld_o;
    o.left  = left_o;
    o.up    = up_o;
    return o;
  endfunction

  task automatic fill_random();
    for (int r = 0; r < MD; r++) begin
      for (int c = 0; c < MD; c++) begin
        a_mat[r][c] = $urandom;
        b_mat[r][c] = $urandom;
      end
    end
  endtask

  // Drives start with dims at the next falling edge: that cycle is cycle 0 of the op.
  task automatic launch(input int dn, input int dk, input int dm);
    @(negedge clk_i);
    start_i = 1'b1;
    dim_n_i = DIMW'(dn);
    dim_k_i = DIMW'(dk);
    dim_m_i = DIMW'(dm);
  endtask

  // Advances to the next cycle, drops start and scrambles dims (they must already be latched).
  task automatic next_cycle(input logic st);
    @(negedge clk_i);
    start_i = st;
    dim_n_i = DIMW'($urandom);
    dim_k_i = DIMW'($urandom);
    dim_m_i = DIMW'($urandom);
  endtask

  task automatic test_reset();
    exp_t got;
    rst_ni = 1'b0;
    start_i = 1'b1;
    #2;
    got = observe();
    tests++;
    if (got !== '0) begin
      fails++;
      $display("FAIL reset_async got=%h exp=0", got);
    end
    repeat (2) @(negedge clk_i);
    got = observe();
    tests++;
    if (got !== '0) begin
      fails++;
      $display("FAIL reset_held got=%h exp=0", got);
    end
    start_i = 1'b0;
    rst_ni = 1'b1;
  endtask

  task automatic test_identity();
    exp_t got, exp;
    for (int r = 0; r < MD; r++) begin
      for (int c = 0; c < MD; c++) begin
        a_mat[r][c] = (r == c) ? 1 : 0;
        b_mat[r][c] = DW'(4 * r + c + 1);
      end
    end
    launch(3, 3, 3);
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) next_cycle(1'b0);
      got = observe();
      exp = model(c, 3, 3, 3, -1);
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL identity c=%0d got=%h exp=%h", c, got, exp);
      end
      if (c >= 6 && c <= 9) begin
        tests++;
        if (up_o[3*DW +: DW] !== DW'(4 * (c - 5))) begin
          fails++;
          $display("FAIL identity_up3 c=%0d got=%0d exp=%0d", c, up_o[3*DW +: DW], 4 * (c - 5));
        end
      end
      tests++;
      if (done_o !== (c == 14) || busy_o !== (c >= 1)) begin
        fails++;
        $display("FAIL identity_done_busy c=%0d got=%b%b", c, done_o, busy_o);
      end
    end
  endtask

  task automatic test_masked();
    exp_t got, exp;
    fill_random();
    launch(1, 2, 0);
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) next_cycle(1'b0);
      got = observe();
      exp = model(c, 1, 2, 0, -1);
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL masked c=%0d got=%h exp=%h", c, got, exp);
      end
      tests++;
      if (left_o[4*DW-1:2*DW] !== '0 || left_vld_o[3:2] !== 2'b00 ||
          up_o[4*DW-1:DW] !== '0 || up_vld_o[3:1] !== 3'b000) begin
        fails++;
        $display("FAIL masked_lanes c=%0d got lv=%b uv=%b exp lv=xx00-high uv=000-high",
                 c, left_vld_o, up_vld_o);
      end
    end
    tests++;
    if (done_o !== 1'b1) begin
      fails++;
      $display("FAIL masked_done got=%b exp=1", done_o);
    end
  endtask

  task automatic test_min();
    exp_t got, exp;
    fill_random();
    launch(0, 0, 0);
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) next_cycle(1'b0);
      got = observe();
      exp = model(c, 0, 0, 0, -1);
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL min c=%0d got=%h exp=%h", c, got, exp);
      end
      tests++;
      if (left_vld_o[0] !== (c == 3) || rd_en_o !== (c == 1) || done_o !== (c == 5)) begin
        fails++;
        $display("FAIL min_pulses c=%0d got lv0=%b rd=%b done=%b", c, left_vld_o[0], rd_en_o,
                 done_o);
      end
    end
  endtask

  task automatic test_ignored_start();
    exp_t got, exp;
    fill_random();
    launch(3, 3, 3);
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) next_cycle(c == 4);
      got = observe();
      exp = model(c, 3, 3, 3, 4);
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL ignored_start c=%0d got=%h exp=%h", c, got, exp);
      end
`ifdef FEEDER_ERR_EN
      tests++;
      if (err_o !== (c == 5)) begin
        fails++;
        $display("FAIL err_pulse c=%0d got=%b exp=%b", c, err_o, c == 5);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    exp_t got, exp;
    fill_random();
    launch(3, 3, 3);
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) next_cycle(1'b0);
      got = observe();
      exp = model(c, 3, 3, 3, -1);
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL pre_reset c=%0d got=%h exp=%h", c, got, exp);
      end
    end
    @(posedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    got = observe();
    tests++;
    if (got !== '0) begin
      fails++;
      $display("FAIL reset_mid_immediate got=%h exp=0", got);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      got = observe();
      tests++;
      if (got !== '0) begin
        fails++;
        $display("FAIL reset_mid_held c=%0d got=%h exp=0", c, got);
      end
    end
    rst_ni = 1'b1;
    fill_random();
    launch(3, 3, 3);
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) next_cycle(1'b0);
      got = observe();
      exp = model(c, 3, 3, 3, -1);
      tests++;
      if (got !== exp) begin
        fails++;
        $display("FAIL restart c=%0d got=%h exp=%h", c, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t got, exp;
    int dn, dk, dm, d, sp;
    for (int op = 0; op < 8; op++) begin
      fill_random();
      dn = $urandom_range(0, 3);
      dk = $urandom_range(0, 3);
      dm = $urandom_range(0, 3);
      d  = dn + dk + dm + 5;
      sp = ($urandom_range(0, 1) == 1) ? $urandom_range(1, d - 1) : -1;
      launch(dn, dk, dm);
      for (int c = 0; c <= d; c++) begin
        if (c > 0) next_cycle(c == sp);
        got = observe();
        exp = model(c, dn, dk, dm, sp);
        tests++;
        if (got !== exp) begin
          fails++;
          $display("FAIL back_to_back op=%0d c=%0d got=%h exp=%h", op, c, got, exp);
        end
        if (c <= 1) begin
          tests++;
          if (clr_o !== (c == 1) || busy_o !== (c == 1)) begin
            fails++;
            $display("FAIL b2b_clr op=%0d c=%0d got clr=%b busy=%b", op, c, clr_o, busy_o);
          end
        end
      end
    end
    @(negedge clk_i);
    start_i = 1'b0;
    tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      fails++;
      $display("FAIL final_idle got busy=%b done=%b exp 0 0", busy_o, done_o);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_masked();
    test_min();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
